// File: rtl/tx_escape_pkg.sv
// rtl/tx_escape_pkg.sv - shared types and constants for the TX escape FIFO
package tx_escape_pkg;

  localparam int unsigned TX_ESC_DEFAULT_W = 8;
  localparam logic [TX_ESC_DEFAULT_W-1:0] TX_ESC_DEFAULT = 8'hB1;

  // Output sequencer: optional ESC prefix, then the word itself, each followed
  // by a wait for the UART to finish (rising edge of its ready line).
  typedef enum logic [2:0] {
    IDLE,
    ESC_SEND,
    ESC_WAIT,
    WORD_SEND,
    WORD_WAIT
  } tx_esc_state_e;

  // Default-width FIFO entry; the top re-declares it at its own DATA_W.
  typedef struct packed {
    logic                        is_cmd;
    logic [TX_ESC_DEFAULT_W-1:0] word;
  } tx_esc_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic single-clock FIFO with occupancy counter
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/tx_escape_fifo.sv
// rtl/tx_escape_fifo.sv - buffered ESC inserter to UART-TX; TX_ESCAPE_OVERFLOW_EN enables sticky overflow flag
module tx_escape_fifo
  import tx_escape_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] ESC    = DATA_W'(TX_ESC_DEFAULT),
  parameter int                DEPTH  = 4,
  localparam int               LW     = $clog2(DEPTH + 1)
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [DATA_W-1:0] DATA_I,
  input  logic              WRITE_I,
  input  logic [DATA_W-1:0] COMMAND_I,
  input  logic              WRITE_COMMAND_I,
  output logic              READY_O,
  output logic [LW-1:0]     LEVEL_O,
  output logic              OVERFLOW_O,
  input  logic              TX_READY_I,
  output logic [DATA_W-1:0] DATA_O,
  output logic              WRITE_O,
  output logic              ESC_DETECTED_O
);

  typedef struct packed {
    logic              is_cmd;
    logic [DATA_W-1:0] word;
  } entry_t;

  entry_t            wr_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              write_req;
  logic              push;
  logic              pop;
  logic              tx_ready_q;
  logic              tx_done;
  tx_esc_state_e     state_q;
  tx_esc_state_e     state_d;
  logic              write_d;
  logic [DATA_W-1:0] data_d;
  logic              esc_det_d;

  assign write_req = WRITE_I | WRITE_COMMAND_I;
  assign READY_O   = ~fifo_full & ~RST_I;
  assign push      = write_req & READY_O;
  assign tx_done   = TX_READY_I & ~tx_ready_q;

  // A command wins over a simultaneous data write; the data word is dropped.
  always_comb begin
    wr_entry = '{is_cmd: 1'b0, word: DATA_I};
    if (WRITE_COMMAND_I) begin
      wr_entry = '{is_cmd: 1'b1, word: COMMAND_I};
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK_I),
    .rst  (RST_I),
    .push (push),
    .pop  (pop),
    .wdata(wr_entry),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(LEVEL_O)
  );

  // Next-state and next-output logic; the head is popped only when its word goes out.
  always_comb begin
    state_d   = state_q;
    write_d   = 1'b0;
    data_d    = DATA_O;
    esc_det_d = ESC_DETECTED_O;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = (head.is_cmd || head.word == ESC) ? ESC_SEND : WORD_SEND;
        end
      end
      ESC_SEND: begin
        if (TX_READY_I) begin
          write_d   = 1'b1;
          data_d    = ESC;
          esc_det_d = 1'b1;
          state_d   = ESC_WAIT;
        end
      end
      ESC_WAIT: begin
        if (tx_done) state_d = WORD_SEND;
      end
      WORD_SEND: begin
        if (TX_READY_I) begin
          write_d   = 1'b1;
          data_d    = head.word;
          esc_det_d = 1'b0;
          pop       = 1'b1;
          state_d   = WORD_WAIT;
        end
      end
      WORD_WAIT: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered UART outputs and the TX ready edge detector.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q        <= IDLE;
      WRITE_O        <= 1'b0;
      DATA_O         <= '0;
      ESC_DETECTED_O <= 1'b0;
      tx_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      WRITE_O        <= write_d;
      DATA_O         <= data_d;
      ESC_DETECTED_O <= esc_det_d;
      tx_ready_q     <= TX_READY_I;
    end
  end

`ifdef TX_ESCAPE_OVERFLOW_EN
  logic overflow_q;

  // Sticky flag for any write attempted while the FIFO is full.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      overflow_q <= 1'b0;
    end else if (write_req && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign OVERFLOW_O = overflow_q;
`else
  assign OVERFLOW_O = 1'b0;
`endif

endmodule

// File: tb/tb_tx_escape_fifo.sv
// tb/tb_tx_escape_fifo.sv - directed self-checking bench for tx_escape_fifo
module tb_tx_escape_fifo;

  localparam int LW = 3;

`ifdef TX_ESCAPE_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RST_I = 1'b1;
  logic [7:0]    DATA_I = '0;
  logic          WRITE_I = 1'b0;
  logic [7:0]    COMMAND_I = '0;
  logic          WRITE_COMMAND_I = 1'b0;
  logic          READY_O;
  logic [LW-1:0] LEVEL_O;
  logic          OVERFLOW_O;
  logic          TX_READY_I = 1'b1;
  logic [7:0]    DATA_O;
  logic          WRITE_O;
  logic          ESC_DETECTED_O;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy = 0;
  int         strobe_cyc = 0;
  int         lvl_max = 0;
  logic       tx_hold = 1'b0;
  logic       esc_seen = 1'b0;
  logic       consec = 1'b0;
  logic       wo_prev = 1'b0;
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  tx_escape_fifo #(
    .DATA_W(8),
    .ESC   (8'hB1),
    .DEPTH (4)
  ) dut (
    .CLK_I          (clk),
    .RST_I          (RST_I),
    .DATA_I         (DATA_I),
    .WRITE_I        (WRITE_I),
    .COMMAND_I      (COMMAND_I),
    .WRITE_COMMAND_I(WRITE_COMMAND_I),
    .READY_O        (READY_O),
    .LEVEL_O        (LEVEL_O),
    .OVERFLOW_O     (OVERFLOW_O),
    .TX_READY_I     (TX_READY_I),
    .DATA_O         (DATA_O),
    .WRITE_O        (WRITE_O),
    .ESC_DETECTED_O (ESC_DETECTED_O)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(20);
    check(tag, got_q.size(), n);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // UART model: busy for three cycles after each strobe, or forced busy by tx_hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (WRITE_O) busy = 3;
      if (tx_hold || busy != 0) begin
        TX_READY_I = 1'b0;
        if (busy != 0) busy--;
      end else begin
        TX_READY_I = 1'b1;
      end
    end
  end

  // Output capture and protocol observation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (WRITE_O) begin
        got_q.push_back({ESC_DETECTED_O, DATA_O});
        strobe_cyc = cyc;
      end
      if (WRITE_O && wo_prev) consec = 1'b1;
      wo_prev = WRITE_O;
      if (ESC_DETECTED_O) esc_seen = 1'b1;
      if (int'(LEVEL_O) > lvl_max) lvl_max = int'(LEVEL_O);
    end
  end

  initial begin
    int c;
    int i;
    int k;

    // Reset state
    tick(1);
    check("ready_in_reset", READY_O, 0);
    tick(2);
    RST_I = 1'b0;
    tick(1);
    check("rst_write_o", WRITE_O, 0);
    check("rst_data_o", DATA_O, 0);
    check("rst_esc_det", ESC_DETECTED_O, 0);
    check("rst_level", LEVEL_O, 0);
    check("rst_overflow", OVERFLOW_O, 0);
    check("rst_ready", READY_O, 1);

    // Plain data word: one strobe, latency two cycles after the push edge
    got_q.delete();
    esc_seen = 1'b0;
    c = cyc;
    WRITE_I = 1'b1;
    DATA_I  = 8'h41;
    tick(1);
    WRITE_I = 1'b0;
    wait_words(1, 60, "t1_count");
    if (got_q.size() >= 1) check("t1_word", got_q[0], 9'h041);
    check("t1_latency", strobe_cyc - c, 3);
    check("t1_esc_never", esc_seen, 0);
    check("t1_data_hold", DATA_O, 8'h41);

    // Data equal to ESC: escaped pair
    got_q.delete();
    WRITE_I = 1'b1;
    DATA_I  = 8'hB1;
    tick(1);
    WRITE_I = 1'b0;
    wait_words(2, 80, "t2_count");
    if (got_q.size() >= 2) begin
      check("t2_esc", got_q[0], 9'h1B1);
      check("t2_word", got_q[1], 9'h0B1);
    end

    // Command and data in the same cycle: only the escaped command goes out
    got_q.delete();
    lvl_max = 0;
    WRITE_I         = 1'b1;
    DATA_I          = 8'h22;
    WRITE_COMMAND_I = 1'b1;
    COMMAND_I       = 8'h05;
    tick(1);
    WRITE_I         = 1'b0;
    WRITE_COMMAND_I = 1'b0;
    wait_words(2, 80, "t3_count");
    if (got_q.size() >= 2) begin
      check("t3_esc", got_q[0], 9'h1B1);
      check("t3_cmd", got_q[1], 9'h005);
    end
    check("t3_level_peak", lvl_max, 1);
    check("t3_no_overflow", OVERFLOW_O, 0);

    // UART held busy: fill to DEPTH, two more writes are dropped
    got_q.delete();
    tx_hold = 1'b1;
    tick(3);
    for (int n = 0; n < 6; n++) begin
      WRITE_I = 1'b1;
      DATA_I  = 8'h10 + 8'(n);
      tick(1);
      if (n == 3) begin
        check("t4_ready_full", READY_O, 0);
        check("t4_level_full", LEVEL_O, 4);
      end
    end
    WRITE_I = 1'b0;
    tick(1);
    check("t4_ready_after", READY_O, 0);
    check("t4_level_after", LEVEL_O, 4);
    check("t4_overflow", OVERFLOW_O, OVF_EXP);
    check("t4_no_output", got_q.size(), 0);
    tx_hold = 1'b0;
    wait_words(4, 150, "t4_count");
    for (int n = 0; n < 4 && n < got_q.size(); n++) begin
      check($sformatf("t4_word%0d", n), got_q[n], 9'h010 + 9'(n));
    end
    check("t4_level_drained", LEVEL_O, 0);

    // Pointer wrap with intermittent UART stalls
    got_q.delete();
    i = 0;
    k = 0;
    while (i < 10 && k < 400) begin
      tx_hold = ((k % 7) == 3) || ((k % 7) == 4);
      if (READY_O) begin
        WRITE_I = 1'b1;
        DATA_I  = 8'(i);
        i++;
      end else begin
        WRITE_I = 1'b0;
      end
      tick(1);
      k++;
    end
    WRITE_I = 1'b0;
    tx_hold = 1'b0;
    check("t5_all_written", i, 10);
    wait_words(10, 300, "t5_count");
    for (int n = 0; n < 10 && n < got_q.size(); n++) begin
      check($sformatf("t5_word%0d", n), got_q[n], 9'(n));
    end

    // Reset while waiting after an inserted ESC
    got_q.delete();
    WRITE_COMMAND_I = 1'b1;
    COMMAND_I       = 8'h7E;
    tick(1);
    WRITE_COMMAND_I = 1'b0;
    WRITE_I = 1'b1;
    DATA_I  = 8'h33;
    tick(1);
    DATA_I  = 8'h34;
    tick(1);
    WRITE_I = 1'b0;
    k = 0;
    while (got_q.size() < 1 && k < 40) begin
      tick(1);
      k++;
    end
    check("t6_esc_count", got_q.size(), 1);
    RST_I = 1'b1;
    tick(1);
    RST_I = 1'b0;
    check("t6_level", LEVEL_O, 0);
    check("t6_write_o", WRITE_O, 0);
    check("t6_data_o", DATA_O, 0);
    check("t6_esc_det", ESC_DETECTED_O, 0);
    tick(30);
    check("t6_no_more", got_q.size(), 1);
    if (got_q.size() >= 1) check("t6_esc_word", got_q[0], 9'h1B1);
    check("t6_level_end", LEVEL_O, 0);
    check("t6_overflow", OVERFLOW_O, 0);

    check("no_back_to_back", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
